// File: rtl/ifmap_skew_feeder.sv
// ifmap_skew_feeder: tile sequencer and diagonal skew stage feeding the ifmap
// edge of a systolic MAC array. It accepts one source vector per cycle while
// streaming, then delays row r by r+1 cycles so the elements enter the array
// on a diagonal. A tile runs IDLE -> START -> STREAM -> DRAIN -> IDLE.
//
// Build option: define IFSKEW_STALL_CNT_EN to enable the source-bubble
// counter on stall_cnt_out. When it is undefined, stall_cnt_out is tied to 0.
`timescale 1ns/1ps
module ifmap_skew_feeder #(
  parameter int MAC_ROW        = 16,
  parameter int IFMAP_BITWIDTH = 16,
  parameter int CNT_BITWIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_in,
  input  logic [CNT_BITWIDTH-1:0]           vec_count_in,
  input  logic                              s_valid_in,
  output logic                              s_ready_out,
  input  logic [MAC_ROW*IFMAP_BITWIDTH-1:0] s_data_in,
  output logic                              ifmap_start_out,
  output logic [MAC_ROW-1:0]                ifmap_enable_out,
  output logic [MAC_ROW*IFMAP_BITWIDTH-1:0] ifmap_data_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic [31:0]                       stall_cnt_out
);

  // The drain phase waits for the element of the final vector to leave the
  // last row, which is MAC_ROW cycles after that vector was accepted.
  localparam int                     DRAIN_W    = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1;
  localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(MAC_ROW - 1);
  localparam logic [DRAIN_W-1:0]     DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [CNT_BITWIDTH-1:0] VEC_ONE   = CNT_BITWIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_BITWIDTH-1:0] vec_left;
  logic [DRAIN_W-1:0]      drain_left;
  logic                    accept;
  logic                    start_ok;

  // A vector moves only when the feeder is streaming and the source offers one.
  assign accept   = s_valid_in & s_ready_out;
  // Zero-length tiles are dropped in IDLE; start is ignored in every other state.
  assign start_ok = (state == IDLE) & start_in & (vec_count_in != '0);

  // Tile sequencer: state, remaining-vector count, drain timer and the
  // registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      vec_left        <= '0;
      drain_left      <= '0;
      s_ready_out     <= 1'b0;
      ifmap_start_out <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      ifmap_start_out <= 1'b0;
      done_out        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state           <= START;
            vec_left        <= vec_count_in;
            ifmap_start_out <= 1'b1;
            busy_out        <= 1'b1;
          end
        end
        START: begin
          state       <= STREAM;
          s_ready_out <= 1'b1;
        end
        STREAM: begin
          if (accept) begin
            // Counts down to zero and stops there; the last accept ends the stream.
            vec_left <= vec_left - VEC_ONE;
            if (vec_left == VEC_ONE) begin
              state       <= DRAIN;
              s_ready_out <= 1'b0;
              drain_left  <= DRAIN_LAST;
            end
          end
        end
        DRAIN: begin
          if (drain_left == '0) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end else begin
            drain_left <= drain_left - DRAIN_ONE;
          end
        end
        default: begin
          state       <= IDLE;
          s_ready_out <= 1'b0;
          busy_out    <= 1'b0;
        end
      endcase
    end
  end

  // Skew network: row r owns r+1 registers. Stage 0 captures the accepted
  // element (or zero on a bubble), so bubbles travel the same diagonal as
  // data and the outputs read zero whenever their enable is low.
  for (genvar r = 0; r < MAC_ROW; r++) begin : g_row
    logic                      vld_p  [0:r];
    logic [IFMAP_BITWIDTH-1:0] data_p [0:r];

    // Row r delay line, cleared on reset so in-flight elements are discarded.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) begin
          vld_p[k]  <= 1'b0;
          data_p[k] <= '0;
        end
      end else begin
        vld_p[0]  <= accept;
        data_p[0] <= accept ? s_data_in[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH] : '0;
        for (int k = 1; k <= r; k++) begin
          vld_p[k]  <= vld_p[k-1];
          data_p[k] <= data_p[k-1];
        end
      end
    end

    assign ifmap_enable_out[r]                                  = vld_p[r];
    assign ifmap_data_out[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH] = data_p[r];
  end

`ifdef IFSKEW_STALL_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt;

  // Source-bubble counter: STREAM cycles without a valid vector, restarted per tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state == STREAM) && !s_valid_in) begin
      stall_cnt <= sat_inc32(stall_cnt);
    end
  end

  assign stall_cnt_out = stall_cnt;
`else
  assign stall_cnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_ifmap_skew_feeder.sv
// Self-checking bench for ifmap_skew_feeder (MAC_ROW=16, IFMAP_BITWIDTH=16).
// Accepted vectors are pushed into per-row expectation queues tagged with the
// cycle they must appear; a monitor pops and compares them as rows emit.
`timescale 1ns/1ps
module tb_ifmap_skew_feeder;
  localparam int R  = 16;
  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_in = 1'b0;
  logic [CW-1:0] vec_count_in = '0;
  logic          s_valid_in = 1'b0;
  logic          s_ready_out;
  logic [R*W-1:0] s_data_in = '0;
  logic          ifmap_start_out;
  logic [R-1:0]  ifmap_enable_out;
  logic [R*W-1:0] ifmap_data_out;
  logic          busy_out;
  logic          done_out;
  logic [31:0]   stall_cnt_out;

  ifmap_skew_feeder #(.MAC_ROW(R), .IFMAP_BITWIDTH(W), .CNT_BITWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .vec_count_in(vec_count_in),
    .s_valid_in(s_valid_in), .s_ready_out(s_ready_out), .s_data_in(s_data_in),
    .ifmap_start_out(ifmap_start_out), .ifmap_enable_out(ifmap_enable_out),
    .ifmap_data_out(ifmap_data_out), .busy_out(busy_out), .done_out(done_out),
    .stall_cnt_out(stall_cnt_out)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    logic [W-1:0] d;
  } exp_t;
  exp_t sb [R][$];

  bit mon_en = 1'b0;
  int start_seen = 0, start_cyc = -1, done_seen = 0, done_cyc = -1;

`ifdef IFSKEW_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd1;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  // Monitor: pulse bookkeeping plus per-row scoreboard comparison every cycle.
  always begin : mon
    logic [W-1:0] got;
    @(posedge clk);
    #1;
    if (ifmap_start_out === 1'b1) begin start_seen++; start_cyc = cyc; end
    if (done_out === 1'b1) begin done_seen++; done_cyc = cyc; end
    if (mon_en) begin
      for (int r = 0; r < R; r++) begin
        got = ifmap_data_out[r*W +: W];
        n_run++;
        if (sb[r].size() > 0 && sb[r][0].due == cyc) begin
          if (ifmap_enable_out[r] !== 1'b1 || got !== sb[r][0].d) begin
            n_fail++;
            $display("FAIL row%0d_elem cyc=%0d: en=%b data=%h, expected en=1 data=%h",
                     r, cyc, ifmap_enable_out[r], got, sb[r][0].d);
          end
          void'(sb[r].pop_front());
        end else if (ifmap_enable_out[r] !== 1'b0 || got !== '0) begin
          n_fail++;
          $display("FAIL row%0d_idle cyc=%0d: en=%b data=%h, expected en=0 data=0",
                   r, cyc, ifmap_enable_out[r], got);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  function automatic logic [R*W-1:0] mk_vec(input int n);
    logic [R*W-1:0] v;
    for (int r = 0; r < R; r++) v[r*W +: W] = W'(r * 256 + n);
    return v;
  endfunction

  // Called in the cycle a vector is offered and known to be accepted.
  task automatic push_vec(input logic [R*W-1:0] v);
    for (int r = 0; r < R; r++) begin
      exp_t e;
      e.due = cyc + 1 + r;
      e.d   = v[r*W +: W];
      sb[r].push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_in     = (i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      vec_count_in = (i == 2) ? CW'(5) : CW'($urandom);
      s_valid_in   = 1'($urandom_range(0, 1));
      s_data_in    = {8{$urandom}};
      step();
      n_run++;
      if ({ifmap_start_out, ifmap_enable_out, ifmap_data_out, done_out, s_ready_out, stall_cnt_out} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d: start=%b en=%h done=%b rdy=%b stall=%0d, expected all 0",
                 cyc, ifmap_start_out, ifmap_enable_out, done_out, s_ready_out, stall_cnt_out);
      end
      n_run++;
      if (busy_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy cyc=%0d: busy=%b, expected 0", cyc, busy_out);
      end
    end
    rst = 1'b0; start_in = 1'b0; vec_count_in = '0; s_valid_in = 1'b0; s_data_in = '0;
    mon_en = 1'b1;
    step();
    step();
    n_run++;
    if (busy_out !== 1'b0 || ifmap_start_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy=%b start=%b, expected 0 0", busy_out, ifmap_start_out);
    end
  endtask

  task automatic test_basic();
    int t0, s0, d0;
    s0 = start_seen; d0 = done_seen;
    t0 = cyc;
    start_in = 1'b1; vec_count_in = CW'(4); s_valid_in = 1'b1; s_data_in = mk_vec(0);
    step();
    start_in = 1'b0; vec_count_in = '0;
    n_run++;
    if (ifmap_start_out !== 1'b1 || busy_out !== 1'b1 || s_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_start: start=%b busy=%b rdy=%b, expected 1 1 0", ifmap_start_out, busy_out, s_ready_out);
    end
    step();
    for (int n = 0; n < 4; n++) begin
      s_data_in = mk_vec(n);
      n_run++;
      if (s_ready_out !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_ready n=%0d: rdy=%b, expected 1", n, s_ready_out);
      end
      push_vec(mk_vec(n));
      step();
    end
    n_run++;
    if (s_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain_ready: rdy=%b, expected 0", s_ready_out);
    end
    step_to(t0 + 8);
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (ifmap_enable_out[5] !== 1'b1 || ifmap_data_out[5*W +: W] !== W'(16'h0500 + k)) begin
        n_fail++;
        $display("FAIL basic_row5 k=%0d: en=%b data=%h, expected 1 %h",
                 k, ifmap_enable_out[5], ifmap_data_out[5*W +: W], W'(16'h0500 + k));
      end
      step();
    end
    step_to(t0 + 21);
    n_run++;
    if (busy_out !== 1'b1 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain_busy: busy=%b done=%b, expected 1 0", busy_out, done_out);
    end
    step();
    n_run++;
    if (done_out !== 1'b1 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b, expected 1 0", done_out, busy_out);
    end
    step();
    s_valid_in = 1'b0;
    n_run++;
    if (done_seen - d0 != 1 || start_seen - s0 != 1 || start_cyc != t0 + 1 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulses: dones=%0d starts=%0d start_cyc=%0d done_now=%b, expected 1 1 %0d 0",
               done_seen - d0, start_seen - s0, start_cyc, done_out, t0 + 1);
    end
  endtask

  task automatic test_bubbles();
    int t0, d0, j;
    bit [3:0] pat;
    logic [R-1:0] exp_en;
    pat = 4'b1101;
    d0 = done_seen;
    t0 = cyc;
    start_in = 1'b1; vec_count_in = CW'(3); s_valid_in = 1'b0;
    step();
    start_in = 1'b0;
    step();
    for (int k = 0; k < 21; k++) begin
      if (k < 4) begin
        s_valid_in = pat[k];
        s_data_in  = pat[k] ? mk_vec(16 + k) : {8{$urandom}};
        n_run++;
        if (s_ready_out !== 1'b1) begin
          n_fail++;
          $display("FAIL bubble_ready k=%0d: rdy=%b, expected 1", k, s_ready_out);
        end
        if (pat[k]) push_vec(s_data_in);
      end else begin
        s_valid_in = 1'b0;
      end
      if (k >= 1) begin
        exp_en = '0;
        for (int r = 0; r < R; r++) begin
          j = k - 1 - r;
          if (j >= 0 && j < 4) exp_en[r] = pat[j];
        end
        n_run++;
        if (ifmap_enable_out !== exp_en) begin
          n_fail++;
          $display("FAIL bubble_diag k=%0d: en=%h, expected %h", k, ifmap_enable_out, exp_en);
        end
      end
      step();
    end
    n_run++;
    if (done_seen - d0 != 1 || done_cyc != t0 + 22) begin
      n_fail++;
      $display("FAIL bubble_done: dones=%0d at %0d, expected 1 at %0d", done_seen - d0, done_cyc, t0 + 22);
    end
    n_run++;
    if (stall_cnt_out !== EXP_STALL) begin
      n_fail++;
      $display("FAIL bubble_stall: stall=%0d, expected %0d", stall_cnt_out, EXP_STALL);
    end
  endtask

  task automatic test_zero_and_ignore();
    int t0, s0, d0;
    s0 = start_seen;
    start_in = 1'b1; vec_count_in = '0;
    step();
    start_in = 1'b0;
    step();
    n_run++;
    if (busy_out !== 1'b0 || ifmap_start_out !== 1'b0 || start_seen != s0) begin
      n_fail++;
      $display("FAIL zero_count: busy=%b start=%b starts=%0d, expected 0 0 0", busy_out, ifmap_start_out, start_seen - s0);
    end
    s0 = start_seen; d0 = done_seen;
    t0 = cyc;
    start_in = 1'b1; vec_count_in = CW'(2);
    step();
    vec_count_in = CW'(9);
    step();
    s_valid_in = 1'b1; s_data_in = mk_vec(32);
    push_vec(s_data_in);
    step();
    start_in = 1'b0;
    s_data_in = mk_vec(33);
    n_run++;
    if (s_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_ready: rdy=%b, expected 1", s_ready_out);
    end
    push_vec(s_data_in);
    step();
    n_run++;
    if (s_ready_out !== 1'b0 || busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_count: rdy=%b busy=%b after 2 vectors, expected 0 1", s_ready_out, busy_out);
    end
    start_in = 1'b1;
    step();
    start_in = 1'b0; vec_count_in = '0;
    step_to(t0 + 21);
    s_valid_in = 1'b0;
    n_run++;
    if (done_seen - d0 != 1 || done_cyc != t0 + 20 || start_seen - s0 != 1) begin
      n_fail++;
      $display("FAIL ignore_done: dones=%0d at %0d starts=%0d, expected 1 at %0d starts 1",
               done_seen - d0, done_cyc, start_seen - s0, t0 + 20);
    end
  endtask

  task automatic test_reset_mid();
    int t0, t1, d0;
    d0 = done_seen;
    t0 = cyc;
    start_in = 1'b1; vec_count_in = CW'(8);
    step();
    start_in = 1'b0;
    step();
    for (int n = 0; n < 2; n++) begin
      s_valid_in = 1'b1; s_data_in = mk_vec(48 + n);
      push_vec(s_data_in);
      step();
    end
    rst = 1'b1;
    for (int r = 0; r < R; r++) sb[r].delete();
    step();
    rst = 1'b0; s_valid_in = 1'b0;
    n_run++;
    if (ifmap_enable_out !== '0 || s_ready_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: en=%h rdy=%b busy=%b done=%b, expected all 0",
               ifmap_enable_out, s_ready_out, busy_out, done_out);
    end
    step_to(t0 + 30);
    n_run++;
    if (done_seen != d0) begin
      n_fail++;
      $display("FAIL midreset_no_done: dones=%0d, expected 0", done_seen - d0);
    end
    t1 = cyc;
    start_in = 1'b1; vec_count_in = CW'(2);
    step();
    start_in = 1'b0;
    step();
    for (int n = 0; n < 2; n++) begin
      s_valid_in = 1'b1; s_data_in = mk_vec(64 + n);
      push_vec(s_data_in);
      step();
    end
    s_valid_in = 1'b0;
    step_to(t1 + 21);
    n_run++;
    if (done_seen - d0 != 1 || done_cyc != t1 + 20) begin
      n_fail++;
      $display("FAIL midreset_retile: dones=%0d at %0d, expected 1 at %0d", done_seen - d0, done_cyc, t1 + 20);
    end
  endtask

  task automatic test_back_to_back();
    int t0, s0, d0;
    s0 = start_seen; d0 = done_seen;
    t0 = cyc;
    start_in = 1'b1; vec_count_in = CW'(2);
    step();
    start_in = 1'b0;
    step();
    for (int n = 0; n < 2; n++) begin
      s_valid_in = 1'b1; s_data_in = mk_vec(80 + n);
      push_vec(s_data_in);
      step();
    end
    s_valid_in = 1'b0;
    step_to(t0 + 20);
    n_run++;
    if (done_out !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_done: done=%b, expected 1", done_out);
    end
    step();
    start_in = 1'b1; vec_count_in = CW'(2);
    step();
    start_in = 1'b0;
    n_run++;
    if (ifmap_start_out !== 1'b1 || start_cyc != t0 + 22) begin
      n_fail++;
      $display("FAIL b2b_second_start: start=%b at %0d, expected 1 at %0d", ifmap_start_out, start_cyc, t0 + 22);
    end
    step();
    for (int n = 0; n < 2; n++) begin
      s_valid_in = 1'b1; s_data_in = mk_vec(96 + n);
      push_vec(s_data_in);
      step();
    end
    s_valid_in = 1'b0;
    step_to(t0 + 42);
    n_run++;
    if (done_seen - d0 != 2 || start_seen - s0 != 2 || done_cyc != t0 + 41) begin
      n_fail++;
      $display("FAIL b2b_pulses: dones=%0d starts=%0d last_done=%0d, expected 2 2 %0d",
               done_seen - d0, start_seen - s0, done_cyc, t0 + 41);
    end
  endtask

  initial begin
    int left;
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_and_ignore();
    test_reset_mid();
    test_back_to_back();
    step();
    left = 0;
    for (int r = 0; r < R; r++) left += sb[r].size();
    n_run++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d expected elements never emitted, expected 0", left);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
